// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART transmit framer: FSM state encoding and line levels.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_tx_frame_parity_calc.sv
// Combinational parity of the latched transmit word; PAR_ODD inverts the even parity.
module uart_tx_parity_calc
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_c
);

  always_comb begin
    parity_c = ^data;
    if (par_typ == PAR_ODD) parity_c = ~parity_c;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH bits LSB-first, optional parity, stop; one bit per clk.
// Optional macro UART_TX_HOLD_REG_EN adds a one-entry holding register for back-to-back frames.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q;
  logic                  tx_d, busy_d;
  logic                  accept, load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_par_en, load_par_typ;
  logic                  parity_c;

`ifdef UART_TX_HOLD_REG_EN
  logic                  hold_full_q, hold_full_d, hold_wr;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  hold_par_en_q, hold_par_typ_q;
`endif

  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data     (data_q),
    .par_typ  (par_typ_q),
    .parity_c (parity_c)
  );

  // Next state and next line level; TX_OUT/Busy are registered from tx_d/busy_d.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_cnt_inc  = bit_cnt_q + CNT_W'(1);
    tx_d         = IDLE_LEVEL;
    load         = 1'b0;
    load_data    = P_DATA;
    load_par_en  = PAR_EN;
    load_par_typ = PAR_TYP;
    accept       = Data_Valid && !Busy;
`ifdef UART_TX_HOLD_REG_EN
    hold_wr      = 1'b0;
    hold_full_d  = hold_full_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          tx_d    = START_BIT;
          load    = 1'b1;
        end
      end
      ST_START: begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
        tx_d      = data_q[0];
      end
      ST_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = parity_c;
          end else begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
          end
        end else begin
          bit_cnt_d = bit_cnt_inc;
          tx_d      = data_q[bit_cnt_inc];
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = STOP_BIT;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
`ifdef UART_TX_HOLD_REG_EN
        // Chain straight into the next frame when a word is waiting.
        if (hold_full_q) begin
          state_d      = ST_START;
          tx_d         = START_BIT;
          load         = 1'b1;
          load_data    = hold_data_q;
          load_par_en  = hold_par_en_q;
          load_par_typ = hold_par_typ_q;
          hold_full_d  = 1'b0;
        end else if (accept) begin
          state_d = ST_START;
          tx_d    = START_BIT;
          load    = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_TX_HOLD_REG_EN
    if (accept && !load) begin
      hold_wr     = 1'b1;
      hold_full_d = 1'b1;
    end
    busy_d = hold_full_d;
`else
    busy_d = (state_d != ST_IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= IDLE_LEVEL;
      Busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      TX_OUT    <= tx_d;
      Busy      <= busy_d;
      if (load) begin
        data_q    <= load_data;
        par_en_q  <= load_par_en;
        par_typ_q <= load_par_typ;
      end
    end
  end

`ifdef UART_TX_HOLD_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_typ_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (hold_wr) begin
        hold_data_q    <= P_DATA;
        hold_par_en_q  <= PAR_EN;
        hold_par_typ_q <= PAR_TYP;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected line bits queued at accept, popped per cycle.
module tb_uart_tx_frame;
  import uart_tx_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid, PAR_EN, PAR_TYP;
  logic       TX_OUT, Busy;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] w, input logic pen, input logic ptyp);
    exp_q.push_back(START_BIT);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    if (pen) exp_q.push_back((^w) ^ (ptyp == PAR_ODD));
    exp_q.push_back(STOP_BIT);
  endtask

  // Called at a negedge; the next posedge accepts, returns at the start-bit cycle.
  task automatic drive_accept(input logic [7:0] w, input logic pen, input logic ptyp);
    P_DATA = w; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    push_frame(w, pen, ptyp);
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  // Pops nbits expected bits, one per cycle; mask bits pulse Data_Valid with 0x3C.
  task automatic check_frame(input string tag, input int nbits, input logic dv_hold,
                             input int unsigned mask);
    logic e;
    for (int i = 0; i < nbits; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_tx%0d", tag, i), TX_OUT, e);
`ifndef UART_TX_HOLD_REG_EN
      chk($sformatf("%s_busy%0d", tag, i), Busy, 1'b1);
`endif
      Data_Valid = dv_hold | mask[i];
      if (mask[i]) P_DATA = 8'h3C;
      @(negedge clk);
    end
    Data_Valid = dv_hold;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle_tx"}, TX_OUT, IDLE_LEVEL);
    chk({tag, "_idle_busy"}, Busy, 1'b0);
  endtask

  initial begin
    logic e;
    rst = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    drive_accept(8'hA5, 1'b0, PAR_EVEN);
    check_frame("a5_np", 10, 1'b0, 0);
    check_idle("a5_np");

    drive_accept(8'hA5, 1'b1, PAR_EVEN);
    check_frame("a5_even", 11, 1'b0, 0);
    check_idle("a5_even");

    drive_accept(8'hA5, 1'b1, PAR_ODD);
    check_frame("a5_odd", 11, 1'b0, 0);
    check_idle("a5_odd");

    // Inputs changed right after accept must not affect the frame in flight.
    drive_accept(8'h07, 1'b1, PAR_EVEN);
    P_DATA = 8'hFF; PAR_TYP = PAR_ODD; PAR_EN = 1'b0;
    check_frame("x07_even", 11, 1'b0, 0);
    check_idle("x07_even");

`ifndef UART_TX_HOLD_REG_EN
    // Pulses mid-frame and on the stop cycle are dropped.
    drive_accept(8'h96, 1'b1, PAR_ODD);
    check_frame("busy_ign", 11, 1'b0, (32'd1 << 3) | (32'd1 << 10));
    check_idle("busy_ign");
    @(negedge clk);
    check_idle("busy_ign2");

    // Data_Valid held high: second frame starts on the first idle edge.
    P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; Data_Valid = 1'b1;
    push_frame(8'h81, 1'b0, PAR_EVEN);
    @(negedge clk);
    check_frame("cont1", 10, 1'b1, 0);
    check_idle("cont1");
    push_frame(8'h81, 1'b0, PAR_EVEN);
    @(negedge clk);
    Data_Valid = 1'b0;
    check_frame("cont2", 10, 1'b0, 0);
    check_idle("cont2");
`endif

    // Asynchronous reset mid-frame while the line is low.
    drive_accept(8'hC3, 1'b0, PAR_EVEN);
    check_frame("rst_pre", 3, 1'b0, 0);
    e = exp_q.pop_front();
    chk("rst_pre_tx3", TX_OUT, e);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tx", TX_OUT, IDLE_LEVEL);
    chk("rst_mid_busy", Busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_rel");
    drive_accept(8'hA5, 1'b1, PAR_ODD);
    check_frame("post_rst", 11, 1'b0, 0);
    check_idle("post_rst");

`ifdef UART_TX_HOLD_REG_EN
    // 0x11 bypasses the hold, 0x22 waits in it; frames run back to back.
    P_DATA = 8'h11; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; Data_Valid = 1'b1;
    push_frame(8'h11, 1'b0, PAR_EVEN);
    @(negedge clk);
    P_DATA = 8'h22;
    push_frame(8'h22, 1'b0, PAR_EVEN);
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("hold_tx%0d", i), TX_OUT, e);
      chk($sformatf("hold_busy%0d", i), Busy, (i >= 1 && i <= 9));
      @(negedge clk);
      Data_Valid = 1'b0;
    end
    check_idle("hold");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
